// File: rtl/fft_pkt_pkg.sv
// Shared types and helpers for the FFT frame packetizer.
package fft_pkt_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } fft_pkt_state_e;

  localparam int unsigned OVF_CNT_W = 16;

  // Bits needed to index n entries; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_pkt_fifo.sv
// Synchronous show-ahead FIFO: dout_o presents the head entry while not empty.
module fft_pkt_fifo
  import fft_pkt_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int unsigned AW = cnt_width(DEPTH);

  // Pointers carry one extra wrap bit to separate full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_fire  = wr_en_i && !full_o;
    rd_fire  = rd_en_i && !empty_o;
    wr_ptr_d = wr_fire ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    dout_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/fft_frame_packetizer.sv
// Frames a valid-only sample stream into FFT_LENGTH-beat Avalon-ST packets.
// Optional FFT_PKT_OVF_COUNT_EN adds a saturating dropped-sample counter output.
module fft_frame_packetizer
  import fft_pkt_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH = 32,
  parameter int unsigned FFT_LENGTH   = 1024,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset,
  input  logic                    coe_enable,
  output logic                    coe_busy,
  output logic                    coe_overflow,
  input  logic [SYMBOL_WIDTH-1:0] asi_in_data,
  input  logic                    asi_in_valid,
  output logic [SYMBOL_WIDTH-1:0] aso_out_data,
  output logic                    aso_out_valid,
  output logic                    aso_out_startofpacket,
  output logic                    aso_out_endofpacket,
  input  logic                    aso_out_ready
`ifdef FFT_PKT_OVF_COUNT_EN
  ,
  output logic [OVF_CNT_W-1:0]    coe_ovf_count
`endif
);

  localparam int unsigned CntW = cnt_width(FFT_LENGTH);
  localparam logic [CntW-1:0] LastBeat = CntW'(FFT_LENGTH - 1);

  fft_pkt_state_e    state_q, state_d;
  logic [CntW-1:0]   in_cnt_q, in_cnt_d;
  logic [CntW-1:0]   out_cnt_q, out_cnt_d;
  logic              ovf_q, ovf_d;

  logic              fifo_full, fifo_empty;
  logic [SYMBOL_WIDTH-1:0] fifo_dout;
  logic              in_open, eligible, wr_accept, drop, xfer, drained, start_run;

  fft_pkt_fifo #(
    .WIDTH (SYMBOL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (csi_clk),
    .rst_i   (rsi_reset),
    .wr_en_i (wr_accept),
    .din_i   (asi_in_data),
    .rd_en_i (xfer),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  always_comb begin
    // Input stays open in DRAIN only until the current frame is complete.
    in_open   = (state_q == StRun) || ((state_q == StDrain) && (in_cnt_q != '0));
    eligible  = asi_in_valid && in_open;
    wr_accept = eligible && !fifo_full;
    drop      = eligible && fifo_full;
    xfer      = !fifo_empty && aso_out_ready;
    drained   = (in_cnt_q == '0) && fifo_empty && (out_cnt_q == '0);
    start_run = (state_q == StIdle) && coe_enable;

    state_d = state_q;
    case (state_q)
      StIdle:  if (coe_enable) state_d = StRun;
      StRun:   if (!coe_enable) state_d = StDrain;
      StDrain: if (drained) state_d = coe_enable ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    in_cnt_d  = wr_accept ? in_cnt_q + CntW'(1) : in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (xfer) begin
      out_cnt_d = (out_cnt_q == LastBeat) ? '0 : out_cnt_q + CntW'(1);
    end

    ovf_d = ovf_q;
    if (start_run) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    aso_out_valid         = !fifo_empty;
    aso_out_data          = aso_out_valid ? fifo_dout : '0;
    aso_out_startofpacket = aso_out_valid && (out_cnt_q == '0);
    aso_out_endofpacket   = aso_out_valid && (out_cnt_q == LastBeat);
    coe_busy              = (state_q != StIdle);
    coe_overflow          = ovf_q;
  end

`ifdef FFT_PKT_OVF_COUNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (start_run) begin
      ovf_cnt_d = '0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign coe_ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_packetizer.sv
// Directed bench: 8-beat frames, one DUT with a 4-entry FIFO and one with 16.
module tb_fft_frame_packetizer;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, ready;
  logic [31:0] in_data;

  logic        v4, s4, e4, busy4, ovf4;
  logic [31:0] d4;
  logic        v16, s16, e16, busy16, ovf16;
  logic [31:0] d16;
`ifdef FFT_PKT_OVF_COUNT_EN
  logic [15:0] ovfc4, ovfc16;
`endif

  fft_frame_packetizer #(
    .SYMBOL_WIDTH (32),
    .FFT_LENGTH   (8),
    .FIFO_DEPTH   (4)
  ) u_dut4 (
    .csi_clk               (clk),
    .rsi_reset             (rst),
    .coe_enable            (en),
    .coe_busy              (busy4),
    .coe_overflow          (ovf4),
    .asi_in_data           (in_data),
    .asi_in_valid          (in_valid),
    .aso_out_data          (d4),
    .aso_out_valid         (v4),
    .aso_out_startofpacket (s4),
    .aso_out_endofpacket   (e4),
    .aso_out_ready         (ready)
`ifdef FFT_PKT_OVF_COUNT_EN
    ,
    .coe_ovf_count         (ovfc4)
`endif
  );

  fft_frame_packetizer #(
    .SYMBOL_WIDTH (32),
    .FFT_LENGTH   (8),
    .FIFO_DEPTH   (16)
  ) u_dut16 (
    .csi_clk               (clk),
    .rsi_reset             (rst),
    .coe_enable            (en),
    .coe_busy              (busy16),
    .coe_overflow          (ovf16),
    .asi_in_data           (in_data),
    .asi_in_valid          (in_valid),
    .aso_out_data          (d16),
    .aso_out_valid         (v16),
    .aso_out_startofpacket (s16),
    .aso_out_endofpacket   (e16),
    .aso_out_ready         (ready)
`ifdef FFT_PKT_OVF_COUNT_EN
    ,
    .coe_ovf_count         (ovfc16)
`endif
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  beat_t q4[$];
  beat_t q16[$];
  bit    eop_seen, hold_en, prev_hold, busy_watch, busy_fell;
  int    eop_cyc;
  beat_t prev16;
  int    exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Transfer capture and hold-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (v4 && ready) begin
      q4.push_back({s4, e4, d4});
      if (e4) begin
        eop_seen = 1'b1;
        eop_cyc  = cyc;
      end
    end
    if (v16 && ready) q16.push_back({s16, e16, d16});
    if (hold_en && prev_hold) check_eq("hold16", {v16, s16, e16, d16}, {1'b1, prev16});
    prev_hold = v16 && !ready;
    prev16    = {s16, e16, d16};
    if (busy_watch && !busy4) busy_fell = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    q4.delete();
    q16.delete();
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(first + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Beats are frame-aligned from index 0: sop every 8th, eop on the 8th.
  task automatic check_beats(input string tag, input bit use16, input int want[$]);
    beat_t got, exp_b;
    int    n;
    n = use16 ? q16.size() : q4.size();
    check_eq({tag, "_len"}, 64'(n), 64'(want.size()));
    for (int i = 0; i < want.size() && i < n; i++) begin
      got        = use16 ? q16[i] : q4[i];
      exp_b.sop  = (i % 8 == 0);
      exp_b.eop  = (i % 8 == 7);
      exp_b.data = 32'(want[i]);
      check_eq($sformatf("%s_beat%0d", tag, i), 64'(got), 64'(exp_b));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // 1: back-to-back samples, two frames
    do_reset();
    check_eq("rst_outs4", {v4, s4, e4, busy4, ovf4, d4}, 64'd0);
    check_eq("rst_outs16", {v16, s16, e16, busy16, ovf16, d16}, 64'd0);
    en = 1'b1; ready = 1'b1;
    tick();
    check_eq("t1_busy", busy4, 1);
    feed(0, 16);
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    check_beats("t1", 1'b0, exp_q);
    check_eq("t1_ovf", ovf4, 0);

    // 2: sink stalled, FIFO overflows
    do_reset();
    en = 1'b1;
    tick();
    feed(0, 10);
    check_eq("t2_ovf", ovf4, 1);
    check_eq("t2_head", {v4, s4, d4}, {2'b11, 32'd0});
`ifdef FFT_PKT_OVF_COUNT_EN
    check_eq("t2_ovf_cnt", ovfc4, 6);
`endif
    ready = 1'b1;
    idle(6);
    feed(100, 4);
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    for (int i = 0; i < 4; i++) exp_q.push_back(100 + i);
    check_beats("t2", 1'b0, exp_q);
    check_eq("t2_ovf_sticky", ovf4, 1);

    // 3: enable dropped mid-frame, drain to IDLE
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    eop_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k < 10);
      in_data  = 32'(k);
      en       = (k < 4);
      tick();
      if (eop_seen && cyc == eop_cyc + 1) check_eq("t3_busy_eop+1", busy4, 1);
      if (eop_seen && cyc == eop_cyc + 2) check_eq("t3_busy_eop+2", busy4, 0);
    end
    in_valid = 1'b0;
    check_eq("t3_eop_seen", eop_seen, 1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    check_beats("t3", 1'b0, exp_q);
    check_eq("t3_ovf", ovf4, 0);
    check_eq("t3_busy_end", busy4, 0);

    // 4: ready toggling, deep FIFO, output held while stalled
    do_reset();
    en = 1'b1;
    tick();
    prev_hold = 1'b0;
    hold_en   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k < 6);
      in_data  = 32'(k);
      ready    = (k % 2 == 0);
      tick();
    end
    hold_en  = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(i);
    check_beats("t4", 1'b1, exp_q);
    check_eq("t4_ovf", ovf16, 0);

    // 5: reset mid-packet, then a fresh frame
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    feed(0, 6);
    rst = 1'b1; ready = 1'b0;
    tick();
    check_eq("t5_pre_len", 64'(q4.size()), 64'd5);
    check_eq("t5_rst_outs", {v4, s4, e4, busy4, ovf4, d4}, 64'd0);
    rst = 1'b0;
    q4.delete();
    tick();
    ready = 1'b1;
    feed(200, 16);
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(200 + i);
    check_beats("t5", 1'b0, exp_q);

    // 6: enable returns during DRAIN, back to RUN without IDLE
    do_reset();
    en = 1'b1;
    tick();
    feed(0, 6);
    check_eq("t6_ovf_set", ovf4, 1);
    busy_fell  = 1'b0;
    busy_watch = 1'b1;
    en = 1'b0; ready = 1'b1;
    tick();
    feed(10, 4);
    en = 1'b1;
    idle(6);
    feed(20, 8);
    idle(4);
    busy_watch = 1'b0;
    check_eq("t6_busy_fell", busy_fell, 0);
    check_eq("t6_ovf_kept", ovf4, 1);
    check_eq("t6_busy", busy4, 1);
`ifdef FFT_PKT_OVF_COUNT_EN
    check_eq("t6_ovf_cnt", ovfc4, 2);
`endif
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    for (int i = 0; i < 4; i++) exp_q.push_back(10 + i);
    for (int i = 0; i < 8; i++) exp_q.push_back(20 + i);
    check_beats("t6", 1'b0, exp_q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_packetizer.md
Name: fft_frame_packetizer

Overview:
Upstream framing stage for the FFT input path. Takes an unframed, non-backpressurable sample stream (ADC/DDC style valid-only source) and buffers it in a small synchronous FIFO. Emits Avalon-ST packets of exactly FFT_LENGTH beats with startofpacket/endofpacket, which feed the FFT data adapter that prepends the inverse flag. Handles enable/drain at frame boundaries and flags overflow when the sink stalls.

Parameters:
SYMBOL_WIDTH, 32, width of one sample; equals the adapter's INPUT_SYMBOL_WIDTH
FFT_LENGTH, 1024, beats per packet; power of 2, >= 4
FIFO_DEPTH, 16, buffer entries; power of 2, >= 2

Ports:
csi_clk  in  1  clock
rsi_reset  in  1  synchronous active-high reset
coe_enable  in  1  level; high = capture frames
coe_busy  out  1  state != IDLE
coe_overflow  out  1  sticky: a sample was dropped
asi_in_data  in  SYMBOL_WIDTH  sample
asi_in_valid  in  1  sample present (no ready; source cannot stall)
aso_out_data  out  SYMBOL_WIDTH  packet beat
aso_out_valid  out  1  beat valid
aso_out_startofpacket  out  1  first beat of frame
aso_out_endofpacket  out  1  last beat of frame
aso_out_ready  in  1  sink ready

Behaviour:
- Clock csi_clk; reset rsi_reset is synchronous, active-high. All state updates on rising edge.
- Reset: state IDLE, FIFO flushed, in_cnt=0, out_cnt=0; all outputs 0. Reset mid-packet discards the partial frame. The next frame starts with sop.
- States:
  - IDLE -> RUN when coe_enable=1. The transition clears coe_overflow.
  - RUN -> DRAIN when coe_enable=0.
  - DRAIN -> IDLE when in_cnt=0, FIFO empty, output stage empty and out_cnt=0.
  - DRAIN with coe_enable=1 at that exit point -> RUN directly.
- Write side:
  - Sample accepted when asi_in_valid and (RUN, or DRAIN with in_cnt!=0) and FIFO not full.
  - in_cnt counts accepted samples mod FFT_LENGTH. In DRAIN, input closes once in_cnt wraps to 0, so frames are always complete.
  - Samples in IDLE or closed DRAIN are ignored silently; this is not an overflow.
- Overflow:
  - Fullness is evaluated before the same-cycle read. If full and a sample is eligible, the sample is dropped, coe_overflow <= 1 and in_cnt is not incremented.
  - Frame length is preserved; content continuity is not.
- Read side:
  - Show-ahead output register. aso_out_valid rises the cycle after the write edge of the first sample (1-cycle latency). Sustains 1 beat/cycle.
  - Transfer = aso_out_valid && aso_out_ready.
  - While valid && !ready, aso_out_data, sop and eop hold stable.
- Framing:
  - out_cnt increments per transfer and wraps FFT_LENGTH-1 -> 0.
  - aso_out_startofpacket = valid && out_cnt==0.
  - aso_out_endofpacket = valid && out_cnt==FFT_LENGTH-1.
- Widths: counters $clog2(FFT_LENGTH); FIFO pointers $clog2(FIFO_DEPTH)+1 (extra wrap bit for full/empty).

Optional Feature:
FFT_PKT_OVF_COUNT_EN:
- Defined: adds output coe_ovf_count, 16 bits. It counts dropped samples, saturates at 0xFFFF, and clears on reset and on IDLE->RUN.
- Undefined: port and counter are absent; coe_overflow behaviour is identical.

Decomposition:
- Package fft_pkt_pkg: state enum (IDLE, RUN, DRAIN), OVF_CNT_W=16 constant, and a counter-width helper.
- Sub-module fft_pkt_fifo: synchronous show-ahead FIFO (wr_en, rd_en, full, empty, dout; parameters WIDTH, DEPTH).
- The top holds the FSM, in_cnt/out_cnt, overflow logic and sop/eop generation.

Test Plan:
1. FFT_LENGTH=8, FIFO_DEPTH=4, enable=1, samples 0..15 back-to-back, ready=1 -> two packets; sop on 0 and 8, eop on 7 and 15; overflow=0.
2. ready=0 while 10 samples arrive -> 4 stored, 6 dropped; overflow=1; coe_ovf_count=6 (macro on). Then ready=1 -> 4 beats 0..3; sop on beat 0; frame completes with later samples.
3. enable dropped after 4th accepted sample -> samples 4..7 accepted; eop on 7; sample 8 ignored; busy=0 two cycles after eop transfer.
4. Input every cycle, ready toggling 1/0 with FIFO_DEPTH=16, FFT_LENGTH=8, 6 samples -> data held stable while ready=0; all 6 delivered in order; no drop.
5. rsi_reset asserted after 5 beats of a packet -> all outputs 0 next cycle. After re-enable, first beat carries sop, and eop comes 8 beats later.
6. enable re-asserted during DRAIN -> frame completes; block returns to RUN without passing through IDLE; overflow flag stays unchanged.
